// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 integer divider for the EX stage; returns {remainder, quotient}.
// Define DIV_SIGNED_EN to honor signed_div_i (magnitude conversion and sign fix-up); otherwise all divides are unsigned.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_for_ex_o
);

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_e;

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   dividendMag, divisorMag;
    logic [WIDTH-1:0]   quotFix, remFix;
    logic [WIDTH:0]     remShift, trial;

`ifdef DIV_SIGNED_EN
    logic negQuot_q, negQuot_d;
    logic negRem_q, negRem_d;
    logic neg1, neg2;

    always_comb begin
        neg1        = signed_div_i & opdata1_i[WIDTH-1];
        neg2        = signed_div_i & opdata2_i[WIDTH-1];
        dividendMag = neg1 ? -opdata1_i : opdata1_i;
        divisorMag  = neg2 ? -opdata2_i : opdata2_i;
        quotFix     = negQuot_q ? -quot_q : quot_q;
        remFix      = negRem_q ? -rem_q : rem_q;
    end
`else
    logic unusedSignedDiv;

    assign unusedSignedDiv = signed_div_i;

    always_comb begin
        dividendMag = opdata1_i;
        divisorMag  = opdata2_i;
        quotFix     = quot_q;
        remFix      = rem_q;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
`ifdef DIV_SIGNED_EN
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
`ifdef DIV_SIGNED_EN
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
`endif
        end
    end

    // The dividend shifts out of quot_q into the remainder while quotient bits shift in behind it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
`ifdef DIV_SIGNED_EN
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
`endif
        remShift  = {rem_q, quot_q[WIDTH-1]};
        trial     = remShift - {1'b0, divisor_q};

        case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIVZERO;
                    end else begin
                        state_d   = ON;
                        quot_d    = dividendMag;
                        divisor_d = divisorMag;
                        rem_d     = '0;
                        cnt_d     = '0;
`ifdef DIV_SIGNED_EN
                        negQuot_d = neg1 ^ neg2;
                        negRem_d  = neg1;
`endif
                    end
                end
            end
            DIVZERO: begin
                quot_d  = '0;
                rem_d   = '0;
`ifdef DIV_SIGNED_EN
                negQuot_d = 1'b0;
                negRem_d  = 1'b0;
`endif
                state_d = END;
            end
            ON: begin
                cnt_d = cnt_q + 6'd1;
                if (!trial[WIDTH]) begin
                    rem_d  = trial[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = remShift[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_d == 6'(WIDTH)) begin
                    state_d = END;
                end
            end
            END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (annul_i) begin
            state_d = IDLE;
        end
    end

    // Stall drops in END so the pipeline advances on the same edge the result is consumed.
    always_comb begin
        ready_o           = (state_q == END) && !annul_i;
        result_o          = ready_o ? {remFix, quotFix} : '0;
        stallreq_for_ex_o = rst_ni && start_i && !annul_i && (state_q != END);
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized divides
// compared against a plain-arithmetic reference model.
module tb_div_unit;

`ifdef DIV_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    logic        clk;
    logic        rstN;
    logic        start;
    logic        signedDiv;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int assertCount = 0;
    int failCount   = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk_i             (clk),
        .rst_ni            (rstN),
        .start_i           (start),
        .signed_div_i      (signedDiv),
        .opdata1_i         (opA),
        .opdata2_i         (opB),
        .annul_i           (annul),
        .result_o          (result),
        .ready_o           (ready),
        .stallreq_for_ex_o (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division; signed uses truncation toward zero.
    function automatic logic [63:0] refDivide(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        if (b == 32'd0) return 64'd0;
        if (sgn && SignedEn) begin
            sa = $signed(a);
            sb = $signed(b);
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = 32'(sa / sb);
                r = 32'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        opA       = a;
        opB       = b;
        signedDiv = sgn;
        annul     = 1'b0;
        start     = 1'b1;
        #1;
    endtask

    // Issues one divide from a negedge in IDLE and follows it until ready (bounded to 40 cycles).
    task automatic runDivide(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [63:0] expected;
        logic [63:0] res;
        logic        stallHeld;
        logic        stallAtReady;
        int          expLat;
        int          gotLat;
        expected     = refDivide(a, b, sgn);
        expLat       = (b == 32'd0) ? 2 : 33;
        gotLat       = 0;
        stallHeld    = 1'b1;
        stallAtReady = 1'b1;
        res          = '0;
        applyStimulus(a, b, sgn);
        checkOutput({tag, "_stallAccept"}, 64'(stall), 64'd1);
        for (int k = 1; k <= 40 && gotLat == 0; k++) begin
            @(negedge clk);
            if (ready) begin
                gotLat       = k;
                res          = result;
                stallAtReady = stall;
            end else if (!stall) begin
                stallHeld = 1'b0;
            end
            if (k == 1) begin
                opA = $urandom;
                opB = $urandom;
            end
        end
        checkOutput({tag, "_latency"}, 64'(gotLat), 64'(expLat));
        checkOutput({tag, "_result"}, res, expected);
        checkOutput({tag, "_stallAtReady"}, 64'(stallAtReady), 64'd0);
        checkOutput({tag, "_stallHeld"}, 64'(stallHeld), 64'd1);
        start = 1'b0;
        @(negedge clk);
        #1;
        checkOutput({tag, "_readyPulse"}, 64'(ready), 64'd0);
    endtask

    initial begin
        logic        noReady;
        logic [31:0] ra;
        logic [31:0] rb;
        rstN      = 1'b0;
        start     = 1'b0;
        signedDiv = 1'b0;
        annul     = 1'b0;
        opA       = '0;
        opB       = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_result", result, 64'd0);
        checkOutput("reset_ready", 64'(ready), 64'd0);
        checkOutput("reset_stall", 64'(stall), 64'd0);
        rstN = 1'b1;
        @(negedge clk);

        runDivide("u100div7", 32'd100, 32'd7, 1'b0);
        checkOutput("u100div7_const", refDivide(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
        runDivide("divzero", 32'd5, 32'd0, 1'b0);
        runDivide("sNeg7div2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        runDivide("s7divNeg2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        runDivide("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        runDivide("uMaxDivMax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runDivide("uMaxDiv1", 32'hFFFF_FFFF, 32'd1, 1'b0);

        // Annul mid-operation, then confirm no stray completion.
        noReady = 1'b1;
        applyStimulus(32'd500, 32'd7, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ready) noReady = 1'b0;
        end
        annul = 1'b1;
        #1;
        checkOutput("annul_stall", 64'(stall), 64'd0);
        checkOutput("annul_ready", 64'(ready), 64'd0);
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        for (int k = 12; k <= 40; k++) begin
            @(negedge clk);
            if (ready) noReady = 1'b0;
        end
        checkOutput("annul_noReady", 64'(noReady), 64'd1);
        runDivide("afterAnnul", 32'd9, 32'd3, 1'b0);

        // Asynchronous reset in the middle of a divide.
        applyStimulus(32'hDEAD_BEEF, 32'd13, 1'b0);
        repeat (15) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("midReset_result", result, 64'd0);
        checkOutput("midReset_ready", 64'(ready), 64'd0);
        checkOutput("midReset_stall", 64'(stall), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("postReset_ready", 64'(ready), 64'd0);
        checkOutput("postReset_stall", 64'(stall), 64'd0);
        runDivide("afterReset", 32'd1234567, 32'd89, 1'b0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 100);
                2:       rb = -32'($urandom_range(1, 100));
                default: rb = $urandom;
            endcase
            runDivide($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider in the EX stage of the five-stage pipeline. It accepts a divide request from EX and raises `stallreq_for_ex` toward the pipeline controller for as long as it is busy. It returns a 64-bit {remainder, quotient} result with a one-cycle `ready` pulse. It is the sole source of the EX stall request.

## Interface
- `WIDTH`, 32: operand width; quotient and remainder are each `WIDTH` bits.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: divide request from EX; held high by EX while the instruction is stalled.
- `signed_div` input 1: 1 selects signed (DIV), 0 selects unsigned (DIVU). Sampled with `start`.
- `opdata1` input `WIDTH`: dividend, sampled when `start` is accepted.
- `opdata2` input `WIDTH`: divisor, sampled when `start` is accepted.
- `annul` input 1: cancel the operation in flight (pipeline flush).
- `result` output 2*`WIDTH`: {remainder[63:32], quotient[31:0]}; valid only while `ready`=1.
- `ready` output 1: one-cycle completion pulse.
- `stallreq_for_ex` output 1: stall request to the controller.

## Operation
- States: IDLE, DIVZERO, ON, END. Reset state is IDLE.
- IDLE:
  - `start`=1, `annul`=0, `opdata2`=0 -> DIVZERO.
  - `start`=1, `annul`=0, `opdata2`≠0 -> ON.
  - In the ON case, latch operand magnitudes: two's-complement negate any negative operand when the signed path is taken. Also latch both sign bits, clear the partial remainder, and clear the 6-bit counter.
- ON: restoring radix-2 step on each cycle.
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor from rem over `WIDTH`+1 bits. If the result is non-negative, commit it and set quotient LSB=1; otherwise quotient LSB=0.
  - Increment the counter. When the counter reaches `WIDTH` (32) -> END.
- DIVZERO: quotient=0, remainder=0 -> END.
- END:
  - Signed fix-up: negate the quotient if the operand signs differed; the remainder takes the sign of the dividend.
  - Drive `result` and `ready`=1 for this cycle only -> IDLE unconditionally. `start` is not sampled in END.
- `stallreq_for_ex` = `start` & ~`annul` & (state≠END). Combinational, so it is high in the accepting cycle itself and low in the END cycle, which releases the pipeline.
- `annul`=1 in any state -> IDLE on the next edge. No `ready` is produced and `stallreq_for_ex` is 0 in that cycle.
- Overflow: signed −2^31 / −1 -> quotient 0x80000000, remainder 0 (wraps; no trap).
- Outside END: `result`=0, `ready`=0.
- Async reset mid-operation -> IDLE immediately, all outputs 0, operation discarded.

## Timing
- Reset values: `result`=0, `ready`=0, `stallreq_for_ex`=0.
- `start` accepted at edge T (state IDLE). Normal divide: ON for cycles T+1..T+32, END during T+33, `ready` high during T+33.
- Divide by zero: DIVZERO during T+1, `ready` during T+2.
- EX must keep `start` and the operands stable until `ready`. Operands are latched at acceptance and later changes are ignored.
- Back-to-back divides: the next `start` is accepted no earlier than the cycle after END (IDLE). Minimum issue interval is 34 cycles.

## Configuration
- `DIV_SIGNED_EN` defined: `signed_div` is honored, with magnitude conversion and sign fix-up as above.
- `DIV_SIGNED_EN` undefined: `signed_div` is ignored, all divides are unsigned, and the negation logic is not built.

## Test plan
- Unsigned: 100 / 7 -> `ready` at T+33; `result`={0x00000002, 0x0000000E}; `stallreq_for_ex` high T..T+32, low at T+33.
- Signed (`DIV_SIGNED_EN`): −7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / −2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: 5 / 0 -> `ready` at T+2, `result`=0, stall high T..T+1.
- Overflow (`DIV_SIGNED_EN`): 0x80000000 / 0xFFFFFFFF signed -> quotient 0x80000000, remainder 0.
- Annul at cycle T+10 -> `stallreq_for_ex`=0 that cycle, no `ready` through T+40. A new `start` of 9 / 3 then completes with quotient 3, remainder 0, 33 cycles after acceptance.
- Reset asserted at T+15 -> all outputs 0 immediately. After release, state is IDLE and a fresh divide completes normally.
